// File: rtl/mem_banked_sync_if.sv
// Request/response bundle between the datapath's memory port and mem_banked_sync.
// master drives requests; slave (the memory) returns status and read data.
interface mem_banked_sync_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] be;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              addr_err;
  logic              init_done;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, rvalid, addr_err, init_done
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, rvalid, addr_err, init_done
  );
endinterface

// File: rtl/mem_banked_sync.sv
// Banked single-port data memory: byte-enabled writes, 1-cycle registered reads,
// a post-reset clear walk over all rows and out-of-range address flagging.
module mem_banked_sync #(
  parameter int DATA_W         = 16,
  parameter int BANK_BITS      = 3,
  parameter int BANK_AW        = 5,
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mem_banked_sync_if.slave   bus
);

  localparam int NBANK = 1 << BANK_BITS;
  localparam int NROW  = 1 << BANK_AW;
  localparam int NBYTE = DATA_W / 8;
  localparam int IDX_W = BANK_BITS + BANK_AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t               state, state_nx;
  logic [BANK_AW-1:0]   clr_row, clr_row_nx;
  logic                 clr_we;
  logic                 accept;
  logic                 in_range;
  logic                 wr_en;
  logic                 rd_en;
  logic [BANK_BITS-1:0] bank;
  logic [BANK_AW-1:0]   row;

  logic [DATA_W-1:0]    mem [NBANK][NROW];

  assign bank     = bus.addr[IDX_W-1:BANK_AW];
  assign row      = bus.addr[BANK_AW-1:0];
  // Any set bit above the bank field is an error; nothing aliases.
  assign in_range = (bus.addr >> IDX_W) == '0;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    clr_row_nx = clr_row;
    clr_we     = 1'b0;
    accept     = 1'b0;
    case (state)
      CLEAR: begin
        if (CLEAR_ON_RESET) begin
          clr_we     = !rst;
          clr_row_nx = clr_row + 1'b1;
          if (clr_row == '1) state_nx = IDLE;
        end else begin
          state_nx = IDLE;
        end
      end
      IDLE: accept = bus.req && !rst;
    endcase
  end

  assign wr_en = accept && bus.we && in_range;
  assign rd_en = accept && !bus.we;

  // IDLE is only left through rst, so ready and the sticky init_done coincide.
  assign bus.ready     = (state == IDLE);
  assign bus.init_done = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_row      <= '0;
      bus.rvalid   <= 1'b0;
      bus.addr_err <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      state        <= state_nx;
      clr_row      <= clr_row_nx;
      bus.rvalid   <= rd_en;
      bus.addr_err <= accept && !in_range;
      if (rd_en) bus.rdata <= in_range ? mem[bank][row] : '0;
    end
  end

  // NOTE: the array itself has no reset branch; the clear walk zeroes it so it still maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int b = 0; b < NBANK; b++) mem[b][clr_row] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NBYTE; k++)
        if (bus.be[k]) mem[bank][row][8*k +: 8] <= bus.wdata[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_mem_banked_sync.sv
// Scenario bench for mem_banked_sync: a reference array predicts read data,
// expected responses are queued at issue and popped when rvalid appears.
module tb_mem_banked_sync;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [15:0] model [256];
  exp_t        sb [$];

  mem_banked_sync_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_banked_sync #(
    .DATA_W(16), .BANK_BITS(3), .BANK_AW(5), .ADDR_W(16), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; updates the reference and queues expected reads.
  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] b, input logic rs);
    logic rdy;
    exp_t e;
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b; rst = rs;
    rdy = bus.ready;
    @(posedge clk);
    #1;
    if (rs) begin
      sb.delete();
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    end else if (r && rdy === 1'b1) begin
      if (w) begin
        if (a[15:8] == 8'h00)
          for (int k = 0; k < 2; k++)
            if (b[k]) model[a[7:0]][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.data = (a[15:8] == 8'h00) ? model[a[7:0]] : 16'h0000;
        e.err  = (a[15:8] != 8'h00);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0);
  endtask

  // Runs idle cycles until ready, reporting edges taken and any stray rvalid.
  task automatic run_clear(output int cnt, output logic stray);
    cnt   = 0;
    stray = 1'b0;
    do begin
      idle();
      cnt++;
      if (bus.rvalid === 1'b1) stray = 1'b1;
    end while (bus.ready !== 1'b1 && cnt < 100);
  endtask

  task automatic test_reset();
    int          cnt;
    logic        stray;
    exp_t        e;
    logic [15:0] addrs [2];
    addrs[0] = 16'h0000;
    addrs[1] = 16'h00FF;
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    n_cmp++;
    if ({bus.ready, bus.init_done, bus.rvalid, bus.addr_err} !== 4'b0000 || bus.rdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_state: ready/init/rvalid/err=%b%b%b%b rdata=%h, want 0000 0000",
               bus.ready, bus.init_done, bus.rvalid, bus.addr_err, bus.rdata);
    end
    run_clear(cnt, stray);
    n_cmp++;
    if (cnt != 32 || bus.init_done !== 1'b1 || stray) begin
      n_bad++;
      $display("FAIL clear_len: edges=%0d init_done=%b stray=%b, want 32 1 0", cnt, bus.init_done, stray);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, addrs[i], 16'h0000, 2'b00, 1'b0);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
        n_bad++;
        $display("FAIL cleared_read: rvalid=%b queued=%0d, want rvalid=1", bus.rvalid, sb.size());
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || bus.addr_err !== e.err) begin
          n_bad++;
          $display("FAIL cleared_read: addr=%h rdata=%h err=%b, want %h %b", addrs[i], bus.rdata, bus.addr_err, e.data, e.err);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [15:0] a;
    logic        noise;
    exp_t        e;
    noise = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a = 16'(i);
      step(1'b1, 1'b1, a, {5'b0, a[7:5], 3'b0, a[4:0]}, 2'b11, 1'b0);
      if (bus.rvalid !== 1'b0 || bus.addr_err !== 1'b0) noise = 1'b1;
    end
    n_cmp++;
    if (noise) begin
      n_bad++;
      $display("FAIL fill_writes: rvalid/addr_err seen during writes, want both 0");
    end
    for (int i = 0; i < 256; i++) begin
      a = 16'(i);
      step(1'b1, 1'b0, a, 16'h0000, 2'b00, 1'b0);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
        n_bad++;
        $display("FAIL fill_read: addr=%h rvalid=%b queued=%0d, want rvalid=1", a, bus.rvalid, sb.size());
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || bus.addr_err !== e.err) begin
          n_bad++;
          $display("FAIL fill_read: addr=%h rdata=%h err=%b, want %h %b", a, bus.rdata, bus.addr_err, e.data, e.err);
        end
      end
    end
  endtask

  task automatic test_byte_en();
    exp_t e;
    step(1'b1, 1'b1, 16'h0040, 16'hFFFF, 2'b11, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 16'h55AA, 2'b01, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
        n_bad++;
        $display("FAIL byte_en_read: pass=%0d rvalid=%b, want 1", pass, bus.rvalid);
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || e.data !== 16'hFFAA) begin
          n_bad++;
          $display("FAIL byte_en_read: pass=%0d rdata=%h model=%h, want FFAA", pass, bus.rdata, e.data);
        end
      end
      idle();
      n_cmp++;
      if (bus.rvalid !== 1'b0 || bus.rdata !== 16'hFFAA) begin
        n_bad++;
        $display("FAIL rdata_hold: rvalid=%b rdata=%h, want 0 FFAA", bus.rvalid, bus.rdata);
      end
      if (pass == 0) step(1'b1, 1'b1, 16'h0040, 16'h0000, 2'b00, 1'b0);
    end
  endtask

  task automatic test_range();
    exp_t        e;
    logic [15:0] addrs [2];
    addrs[0] = 16'h0000;
    addrs[1] = 16'h0100;
    step(1'b1, 1'b1, 16'h0100, 16'h1234, 2'b11, 1'b0);
    n_cmp++;
    if (bus.addr_err !== 1'b1 || bus.rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_write: addr_err=%b rvalid=%b, want 1 0", bus.addr_err, bus.rvalid);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, addrs[i], 16'h0000, 2'b00, 1'b0);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
        n_bad++;
        $display("FAIL range_read: addr=%h rvalid=%b, want 1", addrs[i], bus.rvalid);
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || bus.addr_err !== e.err) begin
          n_bad++;
          $display("FAIL range_read: addr=%h rdata=%h err=%b, want %h %b", addrs[i], bus.rdata, bus.addr_err, e.data, e.err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] a;
    step(1'b1, 1'b1, 16'h00FF, 16'hA5A5, 2'b11, 1'b0);
    for (int b = 0; b < 8; b++) step(1'b1, 1'b1, 16'(b * 32 + 10), 16'hC000 | 16'(b * 17), 2'b11, 1'b0);
    for (int i = -1; i < 8; i++) begin
      a = (i < 0) ? 16'h00FF : 16'(i * 32 + 10);
      step(1'b1, 1'b0, a, 16'h0000, 2'b00, 1'b0);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_read: addr=%h rvalid=%b, want 1", a, bus.rvalid);
      end else begin
        e = sb.pop_front();
        if (bus.rdata !== e.data || bus.addr_err !== e.err) begin
          n_bad++;
          $display("FAIL b2b_read: addr=%h rdata=%h err=%b, want %h %b", a, bus.rdata, bus.addr_err, e.data, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int   cnt;
    logic stray;
    logic early;
    exp_t e;
    step(1'b1, 1'b1, 16'h00AA, 16'hBEEF, 2'b11, 1'b0);
    step(1'b1, 1'b0, 16'h00AA, 16'h0000, 2'b00, 1'b1);
    n_cmp++;
    if (bus.rvalid !== 1'b0 || bus.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_read: rvalid=%b ready=%b, want 0 0", bus.rvalid, bus.ready);
    end
    run_clear(cnt, stray);
    n_cmp++;
    if (cnt != 32 || stray) begin
      n_bad++;
      $display("FAIL abort_clear: edges=%0d stray=%b, want 32 0", cnt, stray);
    end
    step(1'b1, 1'b0, 16'h00AA, 16'h0000, 2'b00, 1'b0);
    n_cmp++;
    if (bus.rvalid !== 1'b1 || sb.size() == 0) begin
      n_bad++;
      $display("FAIL post_clear_read: rvalid=%b, want 1", bus.rvalid);
    end else begin
      e = sb.pop_front();
      if (bus.rdata !== e.data || e.data !== 16'h0000) begin
        n_bad++;
        $display("FAIL post_clear_read: rdata=%h, want 0000", bus.rdata);
      end
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    early = 1'b0;
    for (int i = 0; i < 17; i++) begin
      idle();
      if (bus.ready !== 1'b0) early = 1'b1;
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    run_clear(cnt, stray);
    n_cmp++;
    if (cnt != 32 || early || bus.init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL midclear_reset: edges=%0d early_ready=%b init_done=%b, want 32 0 1", cnt, early, bus.init_done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    test_reset();
    test_fill();
    test_byte_en();
    test_range();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
